dcache_repair_responder: RTL and testbench
==========================================

# dcache_repair_responder

Arbiter-side responder for the L1 data-cache miss-repair handshake. Accepts read- and write-miss repair requests from the dCache controller, acknowledges each, and fetches the missed 1024-bit block from the next memory level as 128-bit beats. It then returns the assembled block to the controller as a single-cycle `repair_resolved` fill write. Sits inside the memory arbiter, between the controller's repair port and the memory request/response channel.

## Interface
- `ADDR_W`, 32, byte address width
- `BLOCK_B`, 7, log2 bytes per cache block (128 B)
- `BEAT_BITS`, 128, memory response beat width; beats per block = 2^BLOCK_B*8/BEAT_BITS = 8
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `read_repair_request` in 1: controller read-miss request, level, held until acked
- `missed_raddr` in ADDR_W: read-miss byte address, valid with request
- `write_repair_request` in 1: controller write-miss request, level, held until acked
- `missed_waddr` in ADDR_W: write-miss byte address, valid with request
- `read_repair_req_acq` out 1: one-cycle read-request acknowledge
- `write_repair_req_acq` out 1: one-cycle write-request acknowledge
- `repair_resolved` out 1: one-cycle pulse; fill fields valid this cycle
- `fill_waddr` out ADDR_W: block-aligned fill address, low BLOCK_B bits zero
- `fill_wdata` out 1024: assembled block
- `fill_wmask` out 128: all ones when `repair_resolved`, else zero
- `mem_req_valid` out 1: beat read request valid
- `mem_req_ready` in 1: memory accepts request
- `mem_req_addr` out ADDR_W: beat address = block base + beat*16
- `mem_resp_valid` in 1: response beat valid, in request order
- `mem_resp_data` in BEAT_BITS: response beat

## Operation
- Two pending slots, R and W. Each holds a valid bit and a block base address (`addr[ADDR_W-1:BLOCK_B]`).
- Capture: an empty slot with its request high captures the address on the clock edge. The matching `*_req_acq` pulses exactly one cycle later.
- While a slot is occupied, its request is ignored. A held request is captured only after the slot frees.
- No capture occurs in the same cycle the slot frees.
- FSM states: IDLE, ISSUE, FILL, DELIVER.
- IDLE → ISSUE when any slot is valid. Service target is R when R is valid, otherwise W. Read has priority on simultaneous requests.
- Merge: if both slots are valid with equal block base at the time the target is chosen, one fetch serves both. Both slots are cleared on delivery.
- ISSUE: issue 8 beat requests. The request counter advances only on `mem_req_valid & mem_req_ready`.
- ISSUE → FILL after the 8th accepted request. Responses may arrive during ISSUE.
- Response counter (3-bit) writes beat k into `fill_wdata[k*128 +: 128]`.
- FILL → DELIVER on the 8th response.
- DELIVER: drive `repair_resolved`=1, `fill_waddr` = target base, `fill_wmask`='1. Clear the serviced slot(s), then return to IDLE.
- Dirty-victim writeback is out of scope. Fill blocks are written clean; the controller forms metadata.

## Timing
- Reset values: all outputs 0, FSM IDLE, slots invalid, counters 0, `fill_wdata` 0.
- Reset mid-fetch abandons the transfer; late memory responses arriving after reset are ignored while in IDLE.
- Acknowledge: request sampled high at edge t → `*_req_acq` high during cycle t+1 only.
- Minimum latency, request edge to `repair_resolved` (zero-wait memory, responses same cycle as accept not allowed): 1 (capture) + 1 (IDLE→ISSUE) + 8 (issue) + 1 (last response) + 1 (DELIVER) = 12 cycles.
- Counters wrap 7→0 at beat 8; no residual state between blocks.
- `mem_req_valid` is held with a stable address until ready; it deasserts in FILL/DELIVER/IDLE.
- Simultaneous first-cycle R and W requests: both captured the same edge, both acks in cycle t+1. R is served first; W starts at the next IDLE→ISSUE.
- A new miss arriving during DELIVER for the slot being cleared is captured the following cycle at the earliest.

## Structure
- Add to CORE_PKG: `BLOCK_BITS`=1024, `BEAT_BITS`, `BEATS_PER_BLOCK`, and the FSM enum `repair_state_t` {IDLE, ISSUE, FILL, DELIVER}.
- One natural sub-module, `block_beat_assembler`: response counter plus 1024-bit shift/index buffer.
- The responder connects to the controller through the Arbiter modport of ArbiterControllerIF.

## Test plan
- Single read miss at `missed_raddr`=0x0000_1234, zero-wait memory, beats 0..7 = {4{beat_index}} → ack at t+1; `repair_resolved` at t+12 with `fill_waddr`=0x0000_1200, `fill_wdata[k*128+:128]`={4{k}}, mask all ones.
- Simultaneous read 0x2000 and write 0x4080 requests → both acks at t+1; fill 0x2000 delivered first; then a second 8-beat fetch; fill 0x4080 delivered.
- Read 0x3010 plus write 0x3070 (same block) → both acked; exactly 8 memory requests; one `repair_resolved` with `fill_waddr`=0x3000; both slots clear.
- `mem_req_ready` low for 5 cycles on beat 3 → `mem_req_addr` held at base+0x30; no duplicate requests; correct data; delivery 5 cycles later.
- Request held high after ack while slot full → no second ack until delivery; a request still high afterward is captured once.
- Assert `rst` low during FILL beat 4 → all outputs 0 immediately; no `repair_resolved`; a fresh request after release is served normally.

Source files
------------

// File: rtl/dcache_repair_responder_pkg.sv
// Shared constants and FSM encoding for the dCache miss-repair responder.
package dcache_repair_responder_pkg;

  localparam int unsigned BLOCK_BITS      = 1024;
  localparam int unsigned BEAT_BITS       = 128;
  localparam int unsigned BEATS_PER_BLOCK = BLOCK_BITS / BEAT_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FILL,
    DELIVER
  } repair_state_t;

endpackage

// File: rtl/dcache_repair_responder_block_beat_assembler.sv
// Places in-order memory response beats into a block buffer and pulses
// o_done one cycle after the last beat of a block lands.
module block_beat_assembler
  import dcache_repair_responder_pkg::*;
#(
  parameter int unsigned BEAT_W = BEAT_BITS,
  parameter int unsigned BEATS  = BEATS_PER_BLOCK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [BEAT_W-1:0]       i_data,
  output logic [BEAT_W*BEATS-1:0] o_block,
  output logic                    o_done
);

  localparam int unsigned CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]        r_cnt;
  logic [BEAT_W*BEATS-1:0] r_block;
  logic                    r_done;

  // The counter wraps naturally after the last beat, so each block starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_block <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_en && i_valid) begin
        r_block[r_cnt*BEAT_W +: BEAT_W] <= i_data;
        r_cnt                           <= r_cnt + 1'b1;
        r_done                          <= (r_cnt == CNT_W'(BEATS - 1));
      end
    end
  end

  assign o_block = r_block;
  assign o_done  = r_done;

endmodule

// File: rtl/dcache_repair_responder.sv
// Arbiter-side responder: captures read/write miss repairs, fetches the block
// as beats from the next level and returns it as a one-cycle fill write.
module dcache_repair_responder #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BLOCK_B   = 7,
  parameter int unsigned BEAT_BITS = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_repair_request,
  input  logic [ADDR_W-1:0]         missed_raddr,
  input  logic                      write_repair_request,
  input  logic [ADDR_W-1:0]         missed_waddr,
  output logic                      read_repair_req_acq,
  output logic                      write_repair_req_acq,
  output logic                      repair_resolved,
  output logic [ADDR_W-1:0]         fill_waddr,
  output logic [(8<<BLOCK_B)-1:0]   fill_wdata,
  output logic [(1<<BLOCK_B)-1:0]   fill_wmask,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_resp_valid,
  input  logic [BEAT_BITS-1:0]      mem_resp_data
);

  import dcache_repair_responder_pkg::repair_state_t;
  import dcache_repair_responder_pkg::IDLE;
  import dcache_repair_responder_pkg::ISSUE;
  import dcache_repair_responder_pkg::FILL;
  import dcache_repair_responder_pkg::DELIVER;

  localparam int unsigned BLOCK_W = 8 << BLOCK_B;
  localparam int unsigned BEATS   = BLOCK_W / BEAT_BITS;
  localparam int unsigned CNT_W   = $clog2(BEATS);
  localparam int unsigned OFF_W   = BLOCK_B - CNT_W;
  localparam int unsigned BASE_W  = ADDR_W - BLOCK_B;

  repair_state_t      r_state, w_next;
  logic               r_rv, r_wv;
  logic [BASE_W-1:0]  r_rbase, r_wbase;
  logic               r_rack, r_wack;
  logic [BASE_W-1:0]  r_tgt_base;
  logic               r_tgt_r, r_tgt_w;
  logic [CNT_W-1:0]   r_req_cnt;
  logic               w_issue, w_deliver, w_accept, w_merge, w_start;
  logic               w_fill_done;
  logic [BLOCK_W-1:0] w_block;
  logic               w_unused_lsbs;

  assign w_issue   = (r_state == ISSUE);
  assign w_deliver = (r_state == DELIVER);
  assign w_accept  = w_issue && mem_req_ready;
  assign w_merge   = r_rv && r_wv && (r_rbase == r_wbase);
  assign w_start   = (r_state == IDLE) && (w_next == ISSUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (r_rv || r_wv) w_next = ISSUE;
      ISSUE:   if (w_accept && (r_req_cnt == CNT_W'(BEATS - 1))) w_next = FILL;
      FILL:    if (w_fill_done) w_next = DELIVER;
      DELIVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Slots stay occupied through DELIVER, so a held request cannot be
  // re-captured on the same edge that frees its slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rv    <= 1'b0;
      r_wv    <= 1'b0;
      r_rbase <= '0;
      r_wbase <= '0;
      r_rack  <= 1'b0;
      r_wack  <= 1'b0;
    end else begin
      r_rack <= 1'b0;
      r_wack <= 1'b0;
      if (!r_rv && read_repair_request) begin
        r_rv    <= 1'b1;
        r_rbase <= missed_raddr[ADDR_W-1:BLOCK_B];
        r_rack  <= 1'b1;
      end else if (w_deliver && r_tgt_r) begin
        r_rv <= 1'b0;
      end
      if (!r_wv && write_repair_request) begin
        r_wv    <= 1'b1;
        r_wbase <= missed_waddr[ADDR_W-1:BLOCK_B];
        r_wack  <= 1'b1;
      end else if (w_deliver && r_tgt_w) begin
        r_wv <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tgt_base <= '0;
      r_tgt_r    <= 1'b0;
      r_tgt_w    <= 1'b0;
      r_req_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_tgt_base <= r_rv ? r_rbase : r_wbase;
        r_tgt_r    <= r_rv;
        r_tgt_w    <= !r_rv || w_merge;
      end
      if (w_accept) r_req_cnt <= r_req_cnt + 1'b1;
    end
  end

  block_beat_assembler #(
    .BEAT_W (BEAT_BITS),
    .BEATS  (BEATS)
  ) u_assembler (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_issue || (r_state == FILL)),
    .i_valid (mem_resp_valid),
    .i_data  (mem_resp_data),
    .o_block (w_block),
    .o_done  (w_fill_done)
  );

  assign w_unused_lsbs = ^{missed_raddr[BLOCK_B-1:0], missed_waddr[BLOCK_B-1:0]};

  assign read_repair_req_acq  = r_rack;
  assign write_repair_req_acq = r_wack;
  assign repair_resolved      = w_deliver;
  assign fill_waddr           = w_deliver ? {r_tgt_base, {BLOCK_B{1'b0}}} : '0;
  assign fill_wdata           = w_block;
  assign fill_wmask           = w_deliver ? '1 : '0;
  assign mem_req_valid        = w_issue;
  assign mem_req_addr         = w_issue ? {r_tgt_base, r_req_cnt, {OFF_W{1'b0}}} : '0;

endmodule

// File: tb/tb_dcache_repair_responder.sv
// Scoreboard bench for dcache_repair_responder with an in-order memory model.
module tb_dcache_repair_responder;

  localparam int ADDR_W    = 32;
  localparam int BLOCK_B   = 7;
  localparam int BEAT_BITS = 128;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 read_repair_request, write_repair_request;
  logic [ADDR_W-1:0]    missed_raddr, missed_waddr;
  logic                 read_repair_req_acq, write_repair_req_acq, repair_resolved;
  logic [ADDR_W-1:0]    fill_waddr;
  logic [1023:0]        fill_wdata;
  logic [127:0]         fill_wmask;
  logic                 mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0]    mem_req_addr;
  logic                 mem_resp_valid;
  logic [BEAT_BITS-1:0] mem_resp_data;

  dcache_repair_responder #(
    .ADDR_W    (ADDR_W),
    .BLOCK_B   (BLOCK_B),
    .BEAT_BITS (BEAT_BITS)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .read_repair_request  (read_repair_request),
    .missed_raddr         (missed_raddr),
    .write_repair_request (write_repair_request),
    .missed_waddr         (missed_waddr),
    .read_repair_req_acq  (read_repair_req_acq),
    .write_repair_req_acq (write_repair_req_acq),
    .repair_resolved      (repair_resolved),
    .fill_waddr           (fill_waddr),
    .fill_wdata           (fill_wdata),
    .fill_wmask           (fill_wmask),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_addr         (mem_req_addr),
    .mem_resp_valid       (mem_resp_valid),
    .mem_resp_data        (mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; bit simple; } exp_t;
  exp_t sb[$];

  bit          simple_pat = 1'b1;
  bit          resp_hold  = 1'b0;
  int          stall_left = 0;
  bit          stall_check = 1'b0;
  logic [31:0] stall_addr = '0;
  logic [31:0] mq[$];
  int          n_req = 0, n_given = 0;
  int          n_res = 0, res_cyc = 0, n_rack = 0, n_wack = 0, rack_cyc = 0, wack_cyc = 0;

  function automatic logic [127:0] beat_data(input logic [31:0] a, input bit simple);
    logic [31:0] k;
    k = {29'd0, a[6:4]};
    if (simple) return {4{k}};
    return {a, ~a, k, 32'hC0DE_0000 | k};
  endfunction

  function automatic logic [1023:0] block_data(input logic [31:0] base, input bit simple);
    logic [1023:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b[k*128 +: 128] = beat_data(base + 32'(k * 16), simple);
    return b;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Memory: accepts sampled mid-cycle, responses returned in order from the next cycle.
  initial begin
    logic        pend_acc;
    logic [31:0] pend_addr, a;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_req_ready  = 1'b1;
    forever begin
      @(negedge clk);
      pend_acc  = rst && mem_req_valid && mem_req_ready;
      pend_addr = mem_req_addr;
      if (rst && mem_req_valid && !mem_req_ready && stall_check)
        check("stall_addr_hold", mem_req_addr, stall_addr);
      @(posedge clk);
      #1;
      if (pend_acc) begin
        mq.push_back(pend_addr);
        n_req++;
      end
      if (mq.size() > 0 && !resp_hold) begin
        a = mq.pop_front();
        mem_resp_valid = 1'b1;
        mem_resp_data  = beat_data(a, simple_pat);
        n_given++;
      end else begin
        mem_resp_valid = 1'b0;
      end
      if (stall_left > 0 && mem_req_valid && mem_req_addr[6:4] == 3'd3) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  // Monitor: counts acks and checks every fill against the scoreboard.
  initial begin
    exp_t          e;
    logic [1023:0] expd;
    int            bad_k;
    forever begin
      @(negedge clk);
      if (read_repair_req_acq)  begin n_rack++; rack_cyc = cyc; end
      if (write_repair_req_acq) begin n_wack++; wack_cyc = cyc; end
      if (repair_resolved) begin
        n_res++;
        res_cyc = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resolve: actual fill_waddr %0h required no fill", fill_waddr);
        end else begin
          e = sb.pop_front();
          expd = block_data(e.addr, e.simple);
          check("fill_waddr", fill_waddr, e.addr);
          check("fill_wmask", fill_wmask, {128{1'b1}});
          bad_k = -1;
          for (int k = 7; k >= 0; k--)
            if (fill_wdata[k*128 +: 128] !== expd[k*128 +: 128]) bad_k = k;
          n_cmp++;
          if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL fill_wdata beat %0d: actual %h required %h", bad_k,
                     fill_wdata[bad_k*128 +: 128], expd[bad_k*128 +: 128]);
          end
        end
      end
    end
  end

  task automatic issue(input bit r, input bit w, input logic [31:0] ra, input logic [31:0] wa,
                       output int t);
    @(negedge clk);
    read_repair_request  = r;
    write_repair_request = w;
    missed_raddr         = ra;
    missed_waddr         = wa;
    @(posedge clk);
    #1;
    t = cyc;
    @(negedge clk);
    check("read_ack_t1", read_repair_req_acq, r);
    check("write_ack_t1", write_repair_req_acq, w);
  endtask

  task automatic wait_res(input int target, input int budget);
    int i;
    i = 0;
    while (n_res < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    check("resolve_within_budget", n_res >= target, 1);
  endtask

  initial begin
    int t, r0, a0, w0, n0, g0, i;
    read_repair_request  = 1'b0;
    write_repair_request = 1'b0;
    missed_raddr         = '0;
    missed_waddr         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resolved", repair_resolved, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_fill_waddr", fill_waddr, 0);
    check("rst_fill_wmask", fill_wmask, 0);
    check("rst_fill_wdata_or", |fill_wdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single read miss, zero-wait memory.
    simple_pat = 1'b1;
    sb.push_back('{32'h0000_1200, 1'b1});
    r0 = n_req;
    issue(1, 0, 32'h0000_1234, 0, t);
    read_repair_request = 1'b0;
    @(negedge clk);
    check("read_ack_one_cycle", read_repair_req_acq, 0);
    wait_res(1, 40);
    check("latency_min", res_cyc - t + 1, 12);
    check("single_req_count", n_req - r0, 8);

    // Simultaneous read and write, read served first.
    simple_pat = 1'b0;
    sb.push_back('{32'h0000_2000, 1'b0});
    sb.push_back('{32'h0000_4080, 1'b0});
    r0 = n_req; a0 = n_rack; w0 = n_wack; n0 = n_res;
    issue(1, 1, 32'h0000_2000, 32'h0000_4080, t);
    read_repair_request  = 1'b0;
    write_repair_request = 1'b0;
    wait_res(n0 + 2, 80);
    check("dual_req_count", n_req - r0, 16);
    check("dual_rack_count", n_rack - a0, 1);
    check("dual_wack_count", n_wack - w0, 1);

    // Read and write to the same block share one fetch.
    sb.push_back('{32'h0000_3000, 1'b0});
    r0 = n_req; n0 = n_res;
    issue(1, 1, 32'h0000_3010, 32'h0000_3070, t);
    read_repair_request  = 1'b0;
    write_repair_request = 1'b0;
    wait_res(n0 + 1, 40);
    repeat (15) @(posedge clk);
    #2;
    check("merge_req_count", n_req - r0, 8);
    check("merge_single_fill", n_res - n0, 1);
    check("merge_idle_after", mem_req_valid, 0);

    // Ready held low for five cycles on beat 3.
    sb.push_back('{32'h0000_6000, 1'b0});
    r0 = n_req; n0 = n_res;
    stall_addr  = 32'h0000_6030;
    stall_check = 1'b1;
    stall_left  = 5;
    issue(1, 0, 32'h0000_6044, 0, t);
    read_repair_request = 1'b0;
    wait_res(n0 + 1, 60);
    stall_check = 1'b0;
    check("stall_latency", res_cyc - t + 1, 17);
    check("stall_req_count", n_req - r0, 8);

    // Request held high across its own service is re-captured exactly once.
    sb.push_back('{32'h0000_5000, 1'b0});
    sb.push_back('{32'h0000_5000, 1'b0});
    a0 = n_rack; n0 = n_res;
    issue(1, 0, 32'h0000_5000, 0, t);
    wait_res(n0 + 1, 40);
    check("held_no_early_ack", n_rack - a0, 1);
    i = 0;
    while (n_rack - a0 < 2 && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    read_repair_request = 1'b0;
    check("held_recapture_ack", n_rack - a0, 2);
    check("held_recapture_gap", rack_cyc - res_cyc, 2);
    wait_res(n0 + 2, 40);
    repeat (10) @(posedge clk);
    #2;
    check("held_ack_total", n_rack - a0, 2);

    // Reset in the middle of the fill phase abandons the block.
    simple_pat = 1'b1;
    resp_hold  = 1'b1;
    r0 = n_req;
    issue(1, 0, 32'h0000_7000, 0, t);
    read_repair_request = 1'b0;
    i = 0;
    while (n_req - r0 < 8 && i < 50) begin
      @(posedge clk);
      #2;
      i++;
    end
    check("rst_test_reqs", n_req - r0, 8);
    g0 = n_given;
    resp_hold = 1'b0;
    i = 0;
    while (n_given - g0 < 5 && i < 50) begin
      @(posedge clk);
      #2;
      i++;
    end
    n0 = n_res;
    rst = 1'b0;
    #1;
    check("midrst_resolved", repair_resolved, 0);
    check("midrst_req_valid", mem_req_valid, 0);
    check("midrst_req_addr", mem_req_addr, 0);
    check("midrst_fill_wdata_or", |fill_wdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("midrst_no_resolve", n_res - n0, 0);
    simple_pat = 1'b0;
    sb.push_back('{32'h0000_7100, 1'b0});
    issue(1, 0, 32'h0000_7104, 0, t);
    read_repair_request = 1'b0;
    wait_res(n0 + 1, 40);
    check("post_rst_latency", res_cyc - t + 1, 12);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
